mpsoc_pl_led_bram_subsys: RTL and testbench

//  AXI4-Lite slave subsystem on the PS master port (HPM0 path). Exposes a 4-bit LED GPIO

---
 rtl/mpsoc_pl_pkg.sv | 26 ++
 rtl/mpsoc_pl_led_bram_subsys_if.sv | 30 +++
 rtl/mpsoc_pl_bram_sp.sv | 29 ++
 rtl/mpsoc_pl_led_bram_subsys.sv | 178 +++++++++++++++++
 tb/tb_mpsoc_pl_led_bram_subsys.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mpsoc_pl_pkg.sv
// rtl/mpsoc_pl_pkg.sv - shared constants, region/state types and address decode for the LED/BRAM subsystem
package mpsoc_pl_pkg;

  localparam logic [31:0] BASE_ADDR_DEF   = 32'hA000_0000;
  localparam logic [31:0] BRAM_OFFSET_DEF = 32'h0001_0000;
  localparam int          BRAM_DEPTH_DEF  = 2048;
  localparam int          GPIO_WIDTH_DEF  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [13:0] GPIO_DATA_WORD = 14'h0000;
  localparam logic [13:0] GPIO_TRI_WORD  = 14'h0001;

  typedef enum logic [1:0] {REG_GPIO, REG_BRAM, REG_NONE} region_t;
  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_RAM, R_DATA} rstate_t;

  function automatic region_t decode(input logic [15:0] page, input logic [15:0] gpio_page,
                                     input logic [15:0] bram_page);
    if (page == gpio_page) return REG_GPIO;
    if (page == bram_page) return REG_BRAM;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/mpsoc_pl_led_bram_subsys_if.sv
// rtl/mpsoc_pl_led_bram_subsys_if.sv - AXI4-Lite bus bundle between the PS master and the subsystem
interface mpsoc_pl_led_bram_subsys_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/mpsoc_pl_bram_sp.sv
// rtl/mpsoc_pl_bram_sp.sv - single-port synchronous 32-bit RAM with byte enables, 1-cycle read latency
module mpsoc_pl_bram_sp #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   din,
  output logic [31:0]   dout
);

  logic [31:0] mem [DEPTH];

  // dout only moves on a read so a pending response stays stable across later writes
  always_ff @(posedge clk) begin
    if (en) begin
      if (|we) begin
        for (int i = 0; i < 4; i++) begin
          if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
        end
      end else begin
        dout <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mpsoc_pl_led_bram_subsys.sv
// rtl/mpsoc_pl_led_bram_subsys.sv - AXI4-Lite LED GPIO + BRAM slave; MPSOC_PL_GPIO_TRI_EN adds TRI register/port
module mpsoc_pl_led_bram_subsys
  import mpsoc_pl_pkg::*;
#(
  parameter logic [31:0]           BASE_ADDR    = BASE_ADDR_DEF,
  parameter logic [31:0]           BRAM_OFFSET  = BRAM_OFFSET_DEF,
  parameter int                    BRAM_DEPTH   = BRAM_DEPTH_DEF,
  parameter int                    GPIO_WIDTH   = GPIO_WIDTH_DEF,
  parameter logic [GPIO_WIDTH-1:0] GPIO_RST_VAL = '0
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  mpsoc_pl_led_bram_subsys_if.slave s_axi,
  output logic [GPIO_WIDTH-1:0]   led_4bits_tri_o
`ifdef MPSOC_PL_GPIO_TRI_EN
  ,
  output logic [GPIO_WIDTH-1:0]   led_4bits_tri_t
`endif
);

  localparam int          AW        = $clog2(BRAM_DEPTH);
  localparam logic [31:0] BRAM_BASE = BASE_ADDR + BRAM_OFFSET;

  wstate_t w_state, w_next;
  rstate_t r_state, r_next;

  logic                  aw_held, w_held, awready_q, wready_q, arready_q;
  logic [31:2]           aw_addr, ar_addr;
  logic [31:0]           w_data, rd_hold, ram_dout, gpio_rd;
  logic [3:0]            w_strb, ram_we;
  logic [1:0]            bresp_q, rresp_q;
  logic                  rd_from_ram, commit, rd_stall, ram_en;
  logic [AW-1:0]         ram_addr;
  logic [GPIO_WIDTH-1:0] gpio_data;
  region_t               w_region, r_region;
  logic                  w_bram_hit, r_bram_hit, w_ok, r_ok;
  logic                  unused_addr_bits;

  function automatic logic in_bram(input logic [13:0] word);
    return int'({18'b0, word}) < BRAM_DEPTH;
  endfunction

  assign w_region   = decode(aw_addr[31:16], BASE_ADDR[31:16], BRAM_BASE[31:16]);
  assign r_region   = decode(ar_addr[31:16], BASE_ADDR[31:16], BRAM_BASE[31:16]);
  assign w_bram_hit = (w_region == REG_BRAM) && in_bram(aw_addr[15:2]);
  assign r_bram_hit = (r_region == REG_BRAM) && in_bram(ar_addr[15:2]);
  assign w_ok       = (w_region == REG_GPIO) || w_bram_hit;
  assign r_ok       = (r_region == REG_GPIO) || r_bram_hit;
  assign unused_addr_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:   if (aw_held && w_held) w_next = W_COMMIT;
      W_COMMIT: w_next = W_RESP;
      W_RESP:   if (s_axi.bready) w_next = W_IDLE;
      default:  w_next = W_IDLE;
    endcase
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (arready_q && s_axi.arvalid) r_next = R_RAM;
      R_RAM:   if (!rd_stall) r_next = R_DATA;
      R_DATA:  if (s_axi.rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // a committing BRAM write owns the single RAM port; a BRAM read waits one cycle behind it
  always_comb begin
    commit       = (w_state == W_COMMIT);
    s_axi.bvalid = (w_state == W_RESP);
    s_axi.rvalid = (r_state == R_DATA);
    ram_we       = (commit && w_bram_hit) ? w_strb : 4'b0000;
    rd_stall     = (r_state == R_RAM) && r_bram_hit && (|ram_we);
    ram_en       = (|ram_we) || ((r_state == R_RAM) && r_bram_hit);
    ram_addr     = (|ram_we) ? aw_addr[AW+1:2] : ar_addr[AW+1:2];
    s_axi.rdata  = (r_state == R_DATA) ? (rd_from_ram ? ram_dout : rd_hold) : 32'h0;
    s_axi.rresp  = (r_state == R_DATA) ? rresp_q : RESP_OKAY;
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.arready = arready_q;
  assign s_axi.bresp   = bresp_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr   <= '0;
      ar_addr   <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      awready_q <= (w_state == W_IDLE) && s_axi.awvalid && !aw_held && !awready_q;
      wready_q  <= (w_state == W_IDLE) && s_axi.wvalid && !w_held && !wready_q;
      arready_q <= (r_state == R_IDLE) && s_axi.arvalid && !arready_q;
      if (awready_q && s_axi.awvalid) begin
        aw_held <= 1'b1;
        aw_addr <= s_axi.awaddr[31:2];
      end
      if (wready_q && s_axi.wvalid) begin
        w_held <= 1'b1;
        w_data <= s_axi.wdata;
        w_strb <= s_axi.wstrb;
      end
      if ((w_state == W_RESP) && s_axi.bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (arready_q && s_axi.arvalid) ar_addr <= s_axi.araddr[31:2];
      if (commit) bresp_q <= w_ok ? RESP_OKAY : RESP_DECERR;
    end
  end

`ifdef MPSOC_PL_GPIO_TRI_EN
  logic [GPIO_WIDTH-1:0] gpio_tri;
  assign led_4bits_tri_t = gpio_tri;
`endif

  always_comb begin
    gpio_rd = 32'h0;
    if (ar_addr[15:2] == GPIO_DATA_WORD) gpio_rd = 32'(gpio_data);
`ifdef MPSOC_PL_GPIO_TRI_EN
    if (ar_addr[15:2] == GPIO_TRI_WORD) gpio_rd = 32'(gpio_tri);
`endif
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      gpio_data   <= GPIO_RST_VAL;
`ifdef MPSOC_PL_GPIO_TRI_EN
      gpio_tri    <= '1;
`endif
      rd_hold     <= '0;
      rresp_q     <= RESP_OKAY;
      rd_from_ram <= 1'b0;
    end else begin
      if (commit && (w_region == REG_GPIO) && w_strb[0]) begin
        if (aw_addr[15:2] == GPIO_DATA_WORD) gpio_data <= w_data[GPIO_WIDTH-1:0];
`ifdef MPSOC_PL_GPIO_TRI_EN
        if (aw_addr[15:2] == GPIO_TRI_WORD) gpio_tri <= w_data[GPIO_WIDTH-1:0];
`endif
      end
      if ((r_state == R_RAM) && !rd_stall) begin
        rresp_q     <= r_ok ? RESP_OKAY : RESP_DECERR;
        rd_hold     <= (r_region == REG_GPIO) ? gpio_rd : 32'h0;
        rd_from_ram <= r_bram_hit;
      end
    end
  end

  assign led_4bits_tri_o = gpio_data;

  mpsoc_pl_bram_sp #(.DEPTH(BRAM_DEPTH), .AW(AW)) u_bram (
    .clk  (ACLK),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (w_data),
    .dout (ram_dout)
  );

endmodule

// File: tb/tb_mpsoc_pl_led_bram_subsys.sv
// tb/tb_mpsoc_pl_led_bram_subsys.sv - randomized self-checking bench for the LED/BRAM AXI4-Lite subsystem
module tb_mpsoc_pl_led_bram_subsys;

  localparam int BOUND = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] led;
`ifdef MPSOC_PL_GPIO_TRI_EN
  logic [3:0] led_t;
`endif

  mpsoc_pl_led_bram_subsys_if bus ();

  mpsoc_pl_led_bram_subsys dut (
    .ACLK            (clk),
    .ARESET          (rst),
    .s_axi           (bus),
    .led_4bits_tri_o (led)
`ifdef MPSOC_PL_GPIO_TRI_EN
    ,
    .led_4bits_tri_t (led_t)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0]  gpio_model;
  logic [31:0] mem_model [int];

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    if (a >= 32'hA000_0000 && a < 32'hA001_0000) return 2'b00;
    if (a >= 32'hA001_0000 && a < 32'hA001_0000 + 2048 * 4) return 2'b00;
    return 2'b11;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic send_aw(input logic [31:0] a);
    int n;
    @(posedge clk); #1;
    bus.awaddr = a; bus.awvalid = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!bus.awready && n < BOUND);
    n_checks++;
    if (bus.awready !== 1'b1) begin n_fail++; $display("FAIL aw_accept awready=%b required 1", bus.awready); end
    @(posedge clk); #1 bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n;
    @(posedge clk); #1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!bus.wready && n < BOUND);
    n_checks++;
    if (bus.wready !== 1'b1) begin n_fail++; $display("FAIL w_accept wready=%b required 1", bus.wready); end
    @(posedge clk); #1 bus.wvalid = 1'b0;
  endtask

  task automatic wait_b(input int hold, output logic [1:0] resp);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.bvalid && n < BOUND);
    n_checks++;
    if (bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL b_wait bvalid=%b required 1", bus.bvalid); end
    resp = bus.bresp;
    repeat (hold) begin
      @(negedge clk);
      n_checks++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== resp) begin
        n_fail++; $display("FAIL b_hold bvalid=%b bresp=%b required 1/%b", bus.bvalid, bus.bresp, resp);
      end
    end
    bus.bready = 1'b1;
    @(posedge clk); #1 bus.bready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit w_first, input int hold, output logic [1:0] resp);
    if (w_first) begin send_w(d, s); send_aw(a); end
    else begin send_aw(a); send_w(d, s); end
    wait_b(hold, resp);
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold, output logic [31:0] d,
                          output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    bus.araddr = a; bus.arvalid = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!bus.arready && n < BOUND);
    n_checks++;
    if (bus.arready !== 1'b1) begin n_fail++; $display("FAIL ar_accept arready=%b required 1", bus.arready); end
    @(posedge clk); #1 bus.arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.rvalid && n < BOUND);
    n_checks++;
    if (bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL r_wait rvalid=%b required 1", bus.rvalid); end
    d = bus.rdata; resp = bus.rresp;
    repeat (hold) begin
      @(negedge clk);
      n_checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== d || bus.rresp !== resp) begin
        n_fail++; $display("FAIL r_hold rvalid=%b rdata=%h required 1/%h", bus.rvalid, bus.rdata, d);
      end
    end
    bus.rready = 1'b1;
    @(posedge clk); #1 bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
    bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1 rst = 1'b0;
    gpio_model = 4'h0;
    @(negedge clk);
    n_checks++;
    if (led !== 4'h0) begin n_fail++; $display("FAIL reset_led actual %h required 0", led); end
    n_checks++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_handshake actual %b required 00000",
                         {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
    end
    n_checks++;
    if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin
      n_fail++; $display("FAIL reset_resp bresp=%b rresp=%b rdata=%h required 0", bus.bresp, bus.rresp, bus.rdata);
    end
  endtask

  task automatic test_gpio();
    logic [1:0] r; logic [31:0] d;
    axi_write(32'hA000_0000, 32'hFFFF_FFFF, 4'hF, 0, 0, r);
    gpio_model = 4'hF;
    n_checks++;
    if (r !== 2'b00 || led !== gpio_model) begin
      n_fail++; $display("FAIL gpio_write bresp=%b led=%h required 00/%h", r, led, gpio_model);
    end
    axi_read(32'hA000_0000, 1, d, r);
    n_checks++;
    if (d !== {28'b0, gpio_model} || r !== 2'b00) begin
      n_fail++; $display("FAIL gpio_read rdata=%h rresp=%b required %h/00", d, r, {28'b0, gpio_model});
    end
    axi_write(32'hA000_0000, 32'h0000_0005, 4'b1110, 1, 2, r);
    n_checks++;
    if (r !== 2'b00 || led !== gpio_model) begin
      n_fail++; $display("FAIL gpio_nostrb bresp=%b led=%h required 00/%h", r, led, gpio_model);
    end
    axi_write(32'hA000_0003, 32'h0000_0003, 4'hF, 0, 0, r);
    gpio_model = 4'h3;
    n_checks++;
    if (led !== gpio_model) begin n_fail++; $display("FAIL gpio_lowbits led=%h required %h", led, gpio_model); end
    axi_write(32'hA000_0008, 32'h0000_000C, 4'hF, 0, 0, r);
    axi_read(32'hA000_0008, 0, d, r);
    n_checks++;
    if (d !== 32'h0 || r !== 2'b00 || led !== gpio_model) begin
      n_fail++; $display("FAIL gpio_other rdata=%h rresp=%b led=%h required 0/00/%h", d, r, led, gpio_model);
    end
    axi_write(32'hA000_0004, 32'h0000_0006, 4'hF, 0, 0, r);
    axi_read(32'hA000_0004, 0, d, r);
`ifdef MPSOC_PL_GPIO_TRI_EN
    n_checks++;
    if (d !== 32'h6 || led_t !== 4'h6 || r !== 2'b00) begin
      n_fail++; $display("FAIL gpio_tri rdata=%h tri=%h required 6/6", d, led_t);
    end
`else
    n_checks++;
    if (d !== 32'h0 || r !== 2'b00 || led !== gpio_model) begin
      n_fail++; $display("FAIL gpio_tri_absent rdata=%h rresp=%b required 0/00", d, r);
    end
`endif
  endtask

  task automatic test_bram();
    logic [1:0] r; logic [31:0] d, a, wd; logic [3:0] s; int key;
    axi_write(32'hA001_0000, 32'hDEAD_BEEF, 4'hF, 0, 0, r);
    mem_model[0] = 32'hDEAD_BEEF;
    axi_read(32'hA001_0000, 0, d, r);
    n_checks++;
    if (d !== 32'hDEAD_BEEF || r !== 2'b00) begin
      n_fail++; $display("FAIL bram_word rdata=%h rresp=%b required deadbeef/00", d, r);
    end
    axi_write(32'hA001_0004, 32'hFFFF_FFFF, 4'hF, 0, 0, r);
    axi_write(32'hA001_0004, 32'h1234_5678, 4'b0011, 0, 0, r);
    axi_write(32'hA001_0004, 32'h0BAD_0BAD, 4'b0000, 1, 0, r);
    mem_model[1] = merge(merge(32'hFFFF_FFFF, 32'h1234_5678, 4'b0011), 32'h0BAD_0BAD, 4'b0000);
    axi_read(32'hA001_0004, 2, d, r);
    n_checks++;
    if (d !== mem_model[1] || r !== 2'b00) begin
      n_fail++; $display("FAIL bram_strobe rdata=%h rresp=%b required %h/00", d, r, mem_model[1]);
    end
    axi_write(32'hA001_1FFC, 32'h7E57_1A57, 4'hF, 0, 0, r);
    mem_model[2047] = 32'h7E57_1A57;
    axi_read(32'hA001_1FFE, 0, d, r);
    n_checks++;
    if (d !== mem_model[2047] || r !== exp_resp(32'hA001_1FFC)) begin
      n_fail++; $display("FAIL bram_last rdata=%h rresp=%b required %h/00", d, r, mem_model[2047]);
    end
    for (int k = 0; k < 8; k++) begin
      wd = $urandom;
      axi_write(32'hA001_0200 + 32'(k * 4), wd, 4'hF, 0, 0, r);
      mem_model[128 + k] = wd;
    end
    for (int it = 0; it < 24; it++) begin
      key = 128 + int'($urandom_range(0, 7));
      a = 32'hA001_0000 + 32'(key * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom; s = 4'($urandom_range(0, 15));
        axi_write(a, wd, s, bit'($urandom_range(0, 1)), int'($urandom_range(0, 2)), r);
        mem_model[key] = merge(mem_model[key], wd, s);
        n_checks++;
        if (r !== exp_resp(a)) begin n_fail++; $display("FAIL bram_rand_wr bresp=%b required %b", r, exp_resp(a)); end
      end else begin
        axi_read(a, int'($urandom_range(0, 2)), d, r);
        n_checks++;
        if (d !== mem_model[key] || r !== exp_resp(a)) begin
          n_fail++; $display("FAIL bram_rand_rd addr=%h rdata=%h required %h", a, d, mem_model[key]);
        end
      end
    end
  endtask

  task automatic test_decerr();
    logic [1:0] r; logic [31:0] d;
    logic [31:0] bad [2];
    bad[0] = 32'hB000_0000; bad[1] = 32'hA001_2000;
    for (int i = 0; i < 2; i++) begin
      axi_write(bad[i], 32'h5A5A_5A5A, 4'hF, 0, 1, r);
      n_checks++;
      if (r !== exp_resp(bad[i]) || led !== gpio_model) begin
        n_fail++; $display("FAIL decerr_wr addr=%h bresp=%b led=%h required %b/%h", bad[i], r, led, exp_resp(bad[i]), gpio_model);
      end
      axi_read(bad[i], 1, d, r);
      n_checks++;
      if (r !== exp_resp(bad[i]) || d !== 32'h0) begin
        n_fail++; $display("FAIL decerr_rd addr=%h rresp=%b rdata=%h required %b/0", bad[i], r, d, exp_resp(bad[i]));
      end
    end
    axi_read(32'hA001_0000, 0, d, r);
    n_checks++;
    if (d !== mem_model[0]) begin n_fail++; $display("FAIL decerr_bram_intact rdata=%h required %h", d, mem_model[0]); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] rw, rr; logic [31:0] d, wd;
    wd = $urandom;
    axi_write(32'hA001_0044, 32'h4444_0044, 4'hF, 0, 0, rw);
    mem_model[17] = 32'h4444_0044;
    fork
      axi_write(32'hA001_0040, wd, 4'hF, 0, 0, rw);
      axi_read(32'hA001_0044, 0, d, rr);
    join
    mem_model[16] = wd;
    n_checks++;
    if (rw !== 2'b00 || rr !== 2'b00 || d !== mem_model[17]) begin
      n_fail++; $display("FAIL b2b_overlap bresp=%b rresp=%b rdata=%h required 00/00/%h", rw, rr, d, mem_model[17]);
    end
    axi_read(32'hA001_0040, 0, d, rr);
    n_checks++;
    if (d !== mem_model[16]) begin n_fail++; $display("FAIL b2b_raw rdata=%h required %h", d, mem_model[16]); end
  endtask

  task automatic test_w_first_reset();
    int n; logic [1:0] r; logic [31:0] d;
    send_w(32'hCAFE_F00D, 4'hF);
    send_aw(32'hA001_0080);
    mem_model[32] = 32'hCAFE_F00D;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.bvalid && n < BOUND);
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
        n_fail++; $display("FAIL wfirst_bhold bvalid=%b bresp=%b required 1/00", bus.bvalid, bus.bresp);
      end
    end
    rst = 1'b1;
    #2;
    gpio_model = 4'h0;
    n_checks++;
    if (bus.bvalid !== 1'b0 || led !== gpio_model) begin
      n_fail++; $display("FAIL reset_mid_b bvalid=%b led=%h required 0/%h", bus.bvalid, led, gpio_model);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL reset_no_resp bvalid=%b required 0", bus.bvalid); end
    axi_read(32'hA001_0080, 0, d, r);
    n_checks++;
    if (d !== mem_model[32] || r !== 2'b00) begin
      n_fail++; $display("FAIL reset_bram_kept rdata=%h required %h", d, mem_model[32]);
    end
  endtask

  initial begin
    test_reset();
    test_gpio();
    test_bram();
    test_decerr();
    test_back_to_back();
    test_w_first_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
